// File: rtl/rgb888_to_w128_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb888_to_w128_packer_pkg
// Purpose  : Shared definitions for the RGB888 -> 128-bit word gearbox:
//            byte-lane counts, packer phase encoding, FIFO entry layout and
//            the beat-to-stream byte reordering helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rgb888_to_w128_packer_pkg;

    localparam int IN_BYTES  = 12;  // bytes per 4-pixel RGB888 beat
    localparam int OUT_BYTES = 16;  // bytes per packed output word

    // Number of stream bytes currently held in the residue: 0, 12, 8, 4.
    typedef enum logic [1:0] {
        PHASE0 = 2'd0,
        PHASE1 = 2'd1,
        PHASE2 = 2'd2,
        PHASE3 = 2'd3
    } phase_e;

    typedef struct packed {
        logic                   sof;
        logic                   eol;
        logic [OUT_BYTES*8-1:0] data;
    } fifo_entry_t;

    // Input byte 0 sits in the top lane of the beat; the packer works in
    // stream order with byte 0 in the bottom lane, matching the output word.
    function automatic logic [IN_BYTES*8-1:0] beat_to_stream(
        input logic [IN_BYTES*8-1:0] beat
    );
        logic [IN_BYTES*8-1:0] s;
        s = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            s[8*i +: 8] = beat[8*(IN_BYTES-1-i) +: 8];
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb888_to_w128_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Purpose  : Single-clock show-ahead FIFO; head entry is visible on
//            o_rd_data whenever o_empty is low. A write while full is only
//            accepted together with a read.
// Ports    : i_clk, i_rst (sync, active-high)
//            i_wr_en/i_wr_data  write side
//            i_rd_en/o_rd_data  read side (pop on i_rd_en & !o_empty)
//            o_full, o_empty    status flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_addr_w     = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full_count = (c_addr_w+1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem_q [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_addr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_addr_w:0]   r_count_q,  w_count_d;
    logic                w_do_wr, w_do_rd;

    assign o_full    = (r_count_q == c_full_count);
    assign o_empty   = (r_count_q == '0);
    assign o_rd_data = r_mem_q[r_rd_ptr_q];

    // When full, the slot being read this cycle is the one written.
    assign w_do_wr = i_wr_en & (~o_full | i_rd_en);
    assign w_do_rd = i_rd_en & ~o_empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_wr) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_do_rd) w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem_q[r_wr_ptr_q] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/rgb888_to_w128_packer.sv
`default_nettype none
// ============================================================================
// Module   : rgb888_to_w128_packer
// Purpose  : Repacks 96-bit RGB888 beats into dense 128-bit words with
//            per-line zero-padded flush, sof/eol tagging, a show-ahead output
//            FIFO, a sticky overflow flag and a frame-end pulse.
// Ports    : I_clk, I_rst (sync, active-high)
//            I_rgb888_frame_start/_frame_end/_valid/_data  pixel input
//            I_ready, O_valid, O_data, O_sof, O_eol         word output
//            O_frame_end, O_overflow                         status
// Revision : 1.0 - initial release
// ============================================================================
module rgb888_to_w128_packer
    import rgb888_to_w128_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         I_clk,
    input  logic         I_rst,
    input  logic         I_rgb888_frame_start,
    input  logic         I_rgb888_frame_end,
    input  logic         I_rgb888_valid,
    input  logic [95:0]  I_rgb888_data,
    input  logic         I_ready,
    output logic         O_valid,
    output logic [127:0] O_data,
    output logic         O_sof,
    output logic         O_eol,
    output logic         O_frame_end,
    output logic         O_overflow
);

    // Packer state
    phase_e         r_phase_q,     w_phase_d;
    logic [95:0]    r_residue_q,   w_residue_d;
    logic           r_valid_dly_q, w_valid_dly_d;
    logic           r_sof_arm_q,   w_sof_arm_d;
    // Completed-word stage (one cycle)
    logic           r_s1_valid_q,  w_s1_valid_d;
    logic           r_s1_sof_q,    w_s1_sof_d;
    logic           r_s1_eol_q,    w_s1_eol_d;
    logic [127:0]   r_s1_data_q,   w_s1_data_d;
    // Hold stage: delays each word so eol can be applied retroactively
    logic           r_h_valid_q,   w_h_valid_d;
    logic           r_h_sof_q,     w_h_sof_d;
    logic           r_h_eol_q,     w_h_eol_d;
    logic [127:0]   r_h_data_q,    w_h_data_d;
    // Status
    logic           r_eof_pend_q,  w_eof_pend_d;
    logic           r_frame_end_q, w_frame_end_d;
    logic           r_overflow_q,  w_overflow_d;

    logic           w_line_end, w_retro_eol, w_idle;
    logic [95:0]    w_beat, w_res_eff;
    phase_e         w_ph_eff;
    logic           w_fifo_wr, w_fifo_rd, w_fifo_full, w_fifo_empty;
    fifo_entry_t    w_wr_entry, w_head;

    assign w_beat      = beat_to_stream(I_rgb888_data);
    assign w_line_end  = ~I_rgb888_valid & r_valid_dly_q;
    // A line ending in phase0 always has its last word in the s1 stage.
    assign w_retro_eol = w_line_end & (r_phase_q == PHASE0) & ~I_rgb888_frame_start;
    // Held word leaves when a successor arrives or when it carries eol.
    assign w_fifo_wr   = r_h_valid_q & (r_s1_valid_q | r_h_eol_q) & ~I_rgb888_frame_start;
    assign w_fifo_rd   = O_valid & I_ready;
    assign w_idle      = ~r_s1_valid_q & ~r_h_valid_q & w_fifo_empty & ~w_line_end;

    // A frame start behaves as if the packer were already empty, so a beat
    // arriving with it is taken as the first beat of the new frame.
    assign w_ph_eff    = I_rgb888_frame_start ? PHASE0 : r_phase_q;
    assign w_res_eff   = I_rgb888_frame_start ? '0 : r_residue_q;

    always_comb begin
        w_phase_d     = w_ph_eff;
        w_residue_d   = w_res_eff;
        w_valid_dly_d = I_rgb888_valid;
        w_sof_arm_d   = r_sof_arm_q | I_rgb888_frame_start;
        w_s1_valid_d  = 1'b0;
        w_s1_sof_d    = 1'b0;
        w_s1_eol_d    = 1'b0;
        w_s1_data_d   = '0;

        if (I_rgb888_valid) begin
            case (w_ph_eff)
                PHASE0: begin
                    w_residue_d = w_beat;
                    w_phase_d   = PHASE1;
                end
                PHASE1: begin
                    w_s1_valid_d = 1'b1;
                    w_s1_data_d  = {w_beat[31:0], w_res_eff};
                    w_residue_d  = {32'b0, w_beat[95:32]};
                    w_phase_d    = PHASE2;
                end
                PHASE2: begin
                    w_s1_valid_d = 1'b1;
                    w_s1_data_d  = {w_beat[63:0], w_res_eff[63:0]};
                    w_residue_d  = {64'b0, w_beat[95:64]};
                    w_phase_d    = PHASE3;
                end
                default: begin
                    w_s1_valid_d = 1'b1;
                    w_s1_data_d  = {w_beat, w_res_eff[31:0]};
                    w_residue_d  = '0;
                    w_phase_d    = PHASE0;
                end
            endcase
        end else if (w_line_end && !I_rgb888_frame_start && r_phase_q != PHASE0) begin
            // Residue upper lanes are kept zero, so this is the padded flush.
            w_s1_valid_d = 1'b1;
            w_s1_eol_d   = 1'b1;
            w_s1_data_d  = {32'b0, w_res_eff};
            w_residue_d  = '0;
            w_phase_d    = PHASE0;
        end

        if (w_s1_valid_d) begin
            w_s1_sof_d  = w_sof_arm_d;
            w_sof_arm_d = 1'b0;
        end
    end

    always_comb begin
        w_h_valid_d = r_h_valid_q;
        w_h_sof_d   = r_h_sof_q;
        w_h_eol_d   = r_h_eol_q;
        w_h_data_d  = r_h_data_q;
        if (I_rgb888_frame_start) begin
            w_h_valid_d = 1'b0;
        end else if (r_s1_valid_q) begin
            w_h_valid_d = 1'b1;
            w_h_sof_d   = r_s1_sof_q;
            w_h_eol_d   = r_s1_eol_q | w_retro_eol;
            w_h_data_d  = r_s1_data_q;
        end else if (w_fifo_wr) begin
            w_h_valid_d = 1'b0;
        end
    end

    always_comb begin
        w_frame_end_d = 1'b0;
        w_eof_pend_d  = r_eof_pend_q | I_rgb888_frame_end;
        w_overflow_d  = r_overflow_q | (w_fifo_wr & w_fifo_full & ~w_fifo_rd);
        if (I_rgb888_frame_start) begin
            w_frame_end_d = r_eof_pend_q;
            w_eof_pend_d  = 1'b0;
            w_overflow_d  = 1'b0;
        end else if (r_eof_pend_q && w_idle) begin
            w_frame_end_d = 1'b1;
            w_eof_pend_d  = I_rgb888_frame_end;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_phase_q     <= PHASE0;
            r_residue_q   <= '0;
            r_valid_dly_q <= 1'b0;
            r_sof_arm_q   <= 1'b0;
            r_s1_valid_q  <= 1'b0;
            r_s1_sof_q    <= 1'b0;
            r_s1_eol_q    <= 1'b0;
            r_s1_data_q   <= '0;
            r_h_valid_q   <= 1'b0;
            r_h_sof_q     <= 1'b0;
            r_h_eol_q     <= 1'b0;
            r_h_data_q    <= '0;
            r_eof_pend_q  <= 1'b0;
            r_frame_end_q <= 1'b0;
            r_overflow_q  <= 1'b0;
        end else begin
            r_phase_q     <= w_phase_d;
            r_residue_q   <= w_residue_d;
            r_valid_dly_q <= w_valid_dly_d;
            r_sof_arm_q   <= w_sof_arm_d;
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_sof_q    <= w_s1_sof_d;
            r_s1_eol_q    <= w_s1_eol_d;
            r_s1_data_q   <= w_s1_data_d;
            r_h_valid_q   <= w_h_valid_d;
            r_h_sof_q     <= w_h_sof_d;
            r_h_eol_q     <= w_h_eol_d;
            r_h_data_q    <= w_h_data_d;
            r_eof_pend_q  <= w_eof_pend_d;
            r_frame_end_q <= w_frame_end_d;
            r_overflow_q  <= w_overflow_d;
        end
    end

    assign w_wr_entry = '{sof: r_h_sof_q, eol: r_h_eol_q, data: r_h_data_q};

    sync_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (I_clk),
        .i_rst     (I_rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // Stale RAM contents are masked so idle outputs read as zero.
    assign O_valid     = ~w_fifo_empty;
    assign O_data      = O_valid ? w_head.data : '0;
    assign O_sof       = O_valid & w_head.sof;
    assign O_eol       = O_valid & w_head.eol;
    assign O_frame_end = r_frame_end_q;
    assign O_overflow  = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb888_to_w128_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb888_to_w128_packer
// Purpose  : Scoreboard bench for rgb888_to_w128_packer. Directed lines push
//            their expected words; a monitor pops and compares every word
//            the DUT hands over.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb888_to_w128_packer;

    logic         I_clk = 1'b0;
    logic         I_rst = 1'b1;
    logic         I_rgb888_frame_start = 1'b0;
    logic         I_rgb888_frame_end = 1'b0;
    logic         I_rgb888_valid = 1'b0;
    logic [95:0]  I_rgb888_data = '0;
    logic         I_ready = 1'b1;
    logic         O_valid;
    logic [127:0] O_data;
    logic         O_sof;
    logic         O_eol;
    logic         O_frame_end;
    logic         O_overflow;

    typedef struct packed {
        logic         sof;
        logic         eol;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   fe_cnt = 0;

    always #5 I_clk = ~I_clk;

    rgb888_to_w128_packer #(.FIFO_DEPTH(8)) dut (
        .I_clk                (I_clk),
        .I_rst                (I_rst),
        .I_rgb888_frame_start (I_rgb888_frame_start),
        .I_rgb888_frame_end   (I_rgb888_frame_end),
        .I_rgb888_valid       (I_rgb888_valid),
        .I_rgb888_data        (I_rgb888_data),
        .I_ready              (I_ready),
        .O_valid              (O_valid),
        .O_data               (O_data),
        .O_sof                (O_sof),
        .O_eol                (O_eol),
        .O_frame_end          (O_frame_end),
        .O_overflow           (O_overflow)
    );

    // Monitor: a word is consumed at the next rising edge when valid&ready.
    always @(negedge I_clk) begin
        if (!I_rst && O_frame_end) fe_cnt++;
        if (!I_rst && O_valid && I_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got sof=%b eol=%b data=%h, required no word",
                         O_sof, O_eol, O_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({O_sof, O_eol, O_data} !== mon_e) begin
                    errors++;
                    $display("FAIL word: got sof=%b eol=%b data=%h, required sof=%b eol=%b data=%h",
                             O_sof, O_eol, O_data, mon_e.sof, mon_e.eol, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Beat whose stream bytes are s, s+1, ... s+11 (byte 0 in the top lane).
    function automatic logic [95:0] mk_beat(input int s);
        logic [95:0] d;
        for (int i = 0; i < 12; i++) d[8*(11-i) +: 8] = 8'(s + i);
        return d;
    endfunction

    // Word holding n ascending bytes from s in the low lanes, zero above.
    function automatic logic [127:0] exp_word(input int s, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(s + k);
        return w;
    endfunction

    task automatic push(input logic sof, input logic eol, input logic [127:0] data);
        exp_t e;
        e.sof  = sof;
        e.eol  = eol;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_line(input int base, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            I_rgb888_valid = 1'b1;
            I_rgb888_data  = mk_beat(base + 12*b);
            tick();
        end
        I_rgb888_valid = 1'b0;
        I_rgb888_data  = '0;
    endtask

    task automatic frame_start();
        I_rgb888_frame_start = 1'b1;
        tick();
        I_rgb888_frame_start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_valid",     {129'd0, O_valid},     130'd0);
        chk("rst_data",      {2'b0, O_data},        130'd0);
        chk("rst_flags",     {126'd0, O_sof, O_eol, O_frame_end, O_overflow}, 130'd0);
        I_rst = 1'b0;
        tick();

        // ---------------- full line: 4 beats -> 3 words ----------------
        push(1'b1, 1'b0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        push(1'b0, 1'b0, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        push(1'b0, 1'b1, 128'h2F2E2D2C_2B2A2928_27262524_23222120);
        frame_start();
        send_line(0, 4);
        tick();
        drain("full_line");

        // ---------------- partial line: 5 beats -> flush word ----------------
        push(1'b0, 1'b0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        push(1'b0, 1'b0, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        push(1'b0, 1'b0, 128'h2F2E2D2C_2B2A2928_27262524_23222120);
        push(1'b0, 1'b1, 128'h00000000_3B3A3938_37363534_33323130);
        send_line(0, 5);
        tick();
        drain("partial_line");

        // ---------------- backpressure / overflow ----------------
        // 16 beats make 12 words; only the first 8 fit while I_ready is low.
        I_ready = 1'b0;
        frame_start();
        for (int j = 0; j < 8; j++) push(j == 0, 1'b0, exp_word(16*j, 16));
        send_line(0, 16);
        chk("bp_hold_mid", {O_sof, O_eol, O_data},
            {2'b10, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
        repeat (4) tick();
        chk("bp_hold_end", {O_sof, O_eol, O_data},
            {2'b10, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
        chk("bp_overflow", {129'd0, O_overflow}, 130'd1);
        I_ready = 1'b1;
        drain("backpressure");
        chk("bp_overflow_sticky", {129'd0, O_overflow}, 130'd1);

        // ---------------- frame_end waits for the FIFO ----------------
        fe_cnt  = 0;
        I_ready = 1'b0;
        frame_start();
        chk("fs_clears_overflow", {129'd0, O_overflow}, 130'd0);
        push(1'b1, 1'b0, exp_word(16'h10, 16));
        push(1'b0, 1'b0, exp_word(16'h20, 16));
        push(1'b0, 1'b1, exp_word(16'h30, 16));
        send_line(16'h10, 4);
        tick();
        I_rgb888_frame_end = 1'b1;
        tick();
        I_rgb888_frame_end = 1'b0;
        repeat (10) tick();
        chk("fe_blocked", 130'(fe_cnt), 130'd0);
        I_ready = 1'b1;
        drain("frame_end");
        chk("fe_once", 130'(fe_cnt), 130'd1);

        // ---------------- mid-line frame_start discards residue ----------------
        frame_start();
        I_rgb888_valid = 1'b1;
        I_rgb888_data  = mk_beat(16'hA0);
        tick();
        I_rgb888_data  = mk_beat(16'hAC);
        tick();
        I_rgb888_valid = 1'b0;
        I_rgb888_data  = '0;
        push(1'b1, 1'b0, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
        push(1'b0, 1'b0, 128'h5F5E5D5C_5B5A5958_57565554_53525150);
        push(1'b0, 1'b1, 128'h6F6E6D6C_6B6A6968_67666564_63626160);
        frame_start();
        tick();
        send_line(16'h40, 4);
        tick();
        drain("midline_fs");

        // ---------------- reset mid-line with a full FIFO ----------------
        I_ready = 1'b0;
        frame_start();
        for (int b = 0; b < 15; b++) begin
            I_rgb888_valid = 1'b1;
            I_rgb888_data  = mk_beat(12*b);
            tick();
        end
        chk("pre_rst_full", {128'd0, O_valid, O_overflow}, 130'd3);
        I_rgb888_valid = 1'b0;
        I_rgb888_data  = '0;
        I_rst          = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_valid",    {129'd0, O_valid},     130'd0);
        chk("mid_rst_overflow", {129'd0, O_overflow},  130'd0);
        chk("mid_rst_fe",       {129'd0, O_frame_end}, 130'd0);
        I_rst   = 1'b0;
        I_ready = 1'b1;
        tick();
        push(1'b0, 1'b0, 128'h5F5E5D5C_5B5A5958_57565554_53525150);
        push(1'b0, 1'b0, 128'h6F6E6D6C_6B6A6968_67666564_63626160);
        push(1'b0, 1'b1, 128'h7F7E7D7C_7B7A7978_77767574_73727170);
        send_line(16'h50, 4);
        tick();
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
